// File: rtl/decode_issue_if.sv
// decode_issue_if: IF/ID handshake, pipeline control and ID/EX register bundle for the decode stage
interface decode_issue_if;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        if_ready;
   logic        flush;
   logic        ex_stall;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [2:0]  ex_rs;
   logic [2:0]  ex_rt;
   logic [2:0]  ex_dest;
   logic        ex_wr_en;
   logic        ex_is_load;
   logic [15:0] ex_a;
   logic [15:0] ex_b;
   logic [15:0] ex_imm;
   logic [15:0] ex_pc;
   modport master (output if_valid, if_instr, if_pc, flush, ex_stall,
                   input  if_ready, ex_valid, ex_op, ex_rs, ex_rt, ex_dest, ex_wr_en, ex_is_load,
                          ex_a, ex_b, ex_imm, ex_pc);
   modport slave  (input  if_valid, if_instr, if_pc, flush, ex_stall,
                   output if_ready, ex_valid, ex_op, ex_rs, ex_rt, ex_dest, ex_wr_en, ex_is_load,
                          ex_a, ex_b, ex_imm, ex_pc);
endinterface

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: ID stage with load-use bubbles, stall/flush handling and hazard counting
// Optional DECODE_WB_BYPASS_EN forwards same-edge writeback data into the operands.
module decode_issue_stage #(
   parameter logic [3:0] OP_RTYPE = 4'b0000,
   parameter logic [3:0] OP_LW    = 4'b1000,
   parameter logic [3:0] OP_SW    = 4'b1001,
   parameter logic [3:0] OP_BEQ   = 4'b1011
) (
   input  logic              clk,
   input  logic              rst,
   decode_issue_if.slave     p,
   output logic [2:0]        rf_rd_addr1,
   output logic [2:0]        rf_rd_addr2,
   input  logic [15:0]       rf_rd_data1,
   input  logic [15:0]       rf_rd_data2,
   input  logic              wb_wr_en,
   input  logic [2:0]        wb_dest,
   input  logic [15:0]       wb_data,
   output logic [15:0]       hazard_cnt
);
   logic [3:0]  op;
   logic [2:0]  rs, rt, rd, dest;
   logic        wr_en, hazard;
   logic [15:0] a_val, b_val;
   assign op          = p.if_instr[15:12];
   assign rs          = p.if_instr[11:9];
   assign rt          = p.if_instr[8:6];
   assign rd          = p.if_instr[5:3];
   assign rf_rd_addr1 = rs;
   assign rf_rd_addr2 = rt;
   assign dest        = (op == OP_RTYPE) ? rd : rt;
   assign wr_en       = (op != OP_SW) && (op != OP_BEQ) && (dest != 3'd0);
   assign hazard      = p.if_valid && p.ex_valid && p.ex_is_load && (p.ex_dest != 3'd0) &&
                        ((p.ex_dest == rs) || (p.ex_dest == rt));
   assign p.if_ready  = !hazard && !p.ex_stall;
`ifdef DECODE_WB_BYPASS_EN
   assign a_val = (wb_wr_en && (wb_dest != 3'd0) && (wb_dest == rs)) ? wb_data : rf_rd_data1;
   assign b_val = (wb_wr_en && (wb_dest != 3'd0) && (wb_dest == rt)) ? wb_data : rf_rd_data2;
`else
   assign a_val = rf_rd_data1;
   assign b_val = rf_rd_data2;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p.ex_valid   <= 1'b0;
         p.ex_op      <= '0;
         p.ex_rs      <= '0;
         p.ex_rt      <= '0;
         p.ex_dest    <= '0;
         p.ex_wr_en   <= 1'b0;
         p.ex_is_load <= 1'b0;
         p.ex_a       <= '0;
         p.ex_b       <= '0;
         p.ex_imm     <= '0;
         p.ex_pc      <= '0;
         hazard_cnt   <= '0;
      end else if (p.flush) begin
         p.ex_valid <= 1'b0;
      end else if (!p.ex_stall) begin
         if (hazard) begin
            p.ex_valid <= 1'b0;
            hazard_cnt <= (hazard_cnt == 16'hFFFF) ? hazard_cnt : hazard_cnt + 16'd1;
         end else begin
            // fields capture unconditionally; ex_valid qualifies them downstream
            p.ex_valid   <= p.if_valid;
            p.ex_op      <= op;
            p.ex_rs      <= rs;
            p.ex_rt      <= rt;
            p.ex_dest    <= dest;
            p.ex_wr_en   <= wr_en;
            p.ex_is_load <= (op == OP_LW);
            p.ex_a       <= a_val;
            p.ex_b       <= b_val;
            p.ex_imm     <= {{10{p.if_instr[5]}}, p.if_instr[5:0]};
            p.ex_pc      <= p.if_pc;
         end
      end
   end
endmodule
